// File: rtl/branch_metric_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_metric_unit
// Brief    : Viterbi BMU; builds an expected-codeword table from programmable
//            polynomials, then streams per-branch distance metrics.
//            Soft decision selected by macro BMU_SOFT_DECISION_EN.
// Revision : 1.0 - initial release
// ============================================================================
module branch_metric_unit #(
    parameter int K = 3,
    parameter int N = 2,
    parameter int B = 2,
    parameter int Q = 3,
`ifdef BMU_SOFT_DECISION_EN
    parameter int MW = $clog2(B*N*((1<<Q)-1)+1)
`else
    parameter int MW = $clog2(B*N+1)
`endif
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_cfg_we,
    input  logic [((N>1)?$clog2(N):1)-1:0]      i_cfg_idx,
    input  logic [K-1:0]                        i_cfg_poly,
    input  logic                                i_cfg_start,
    output logic                                o_cfg_busy,
    output logic                                o_ready,
    input  logic                                i_valid,
    input  logic [B*N*Q-1:0]                    i_rx,
    output logic                                o_valid,
    output logic [(1<<(K-1))*(1<<B)*MW-1:0]     o_dist,
    output logic                                o_drop
);

    localparam int S  = 1 << (K-1);
    localparam int NB = 1 << B;
    localparam int CW = B*N;
    localparam int NM = S*NB;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
`ifdef BMU_SOFT_DECISION_EN
    localparam int DW = Q;
`else
    localparam int DW = 1;
`endif
    localparam logic [K-2:0] C_SC_LAST = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUILD = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [K-2:0]        r_sc;
    logic [K-1:0]        r_poly  [N];
    logic [NB*CW-1:0]    r_table [S];
    logic [NB*CW-1:0]    w_cw;
    logic [K-1:0]        w_r;
    logic [K-2:0]        w_st;
    logic [B-1:0]        w_b;
    logic [NM*CW*DW-1:0] w_d1, r_d1;
    logic [NM*MW-1:0]    w_sum, r_dist;
    logic [MW-1:0]       w_acc;
    logic                r_v1, r_valid, r_drop;
    logic                w_ready;

    assign w_ready = (r_state == ST_READY);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (i_cfg_start) w_state_nxt = ST_BUILD;
            ST_BUILD: if (r_sc == C_SC_LAST) w_state_nxt = ST_READY;
            ST_READY: if (i_cfg_start) w_state_nxt = ST_BUILD;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Encoder run for state r_sc: branch bit B-1 is applied first.
    always_comb begin
        w_cw = '0;
        w_r  = '0;
        w_st = '0;
        w_b  = '0;
        for (int b = 0; b < NB; b++) begin
            w_b  = B'(b);
            w_st = r_sc;
            for (int t = 0; t < B; t++) begin
                w_r = {w_b[B-1-t], w_st};
                for (int j = 0; j < N; j++)
                    w_cw[b*CW + t*N + j] = ^(w_r & r_poly[j]);
                w_st = w_r[K-1:1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_sc    <= '0;
            for (int j = 0; j < N; j++) r_poly[j] <= '0;
            for (int s = 0; s < S; s++) r_table[s] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_BUILD) begin
                r_table[r_sc] <= w_cw;
                r_sc          <= r_sc + 1'b1;
            end else begin
                r_sc <= '0;
                for (int j = 0; j < N; j++)
                    if (i_cfg_we && (i_cfg_idx == IW'(j)))
                        r_poly[j] <= i_cfg_poly;
            end
        end
    end

    // Stage-1 per-slot distances; the ideal soft level for bit 1 is all-ones.
    always_comb begin
        w_d1 = '0;
        for (int m = 0; m < NM; m++)
            for (int k = 0; k < CW; k++)
`ifdef BMU_SOFT_DECISION_EN
                w_d1[(m*CW+k)*DW +: DW] = r_table[m/NB][(m%NB)*CW+k] ?
                                          ~i_rx[k*Q +: Q] : i_rx[k*Q +: Q];
`else
                w_d1[(m*CW+k)*DW +: DW] = i_rx[k*Q+Q-1] ^ r_table[m/NB][(m%NB)*CW+k];
`endif
    end

`ifndef BMU_SOFT_DECISION_EN
    logic w_unused_rx;
    assign w_unused_rx = ^i_rx;
`endif

    always_comb begin
        w_sum = '0;
        w_acc = '0;
        for (int m = 0; m < NM; m++) begin
            w_acc = '0;
            for (int k = 0; k < CW; k++)
                w_acc = w_acc + MW'(r_d1[(m*CW+k)*DW +: DW]);
            w_sum[m*MW +: MW] = w_acc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v1    <= 1'b0;
            r_d1    <= '0;
            r_valid <= 1'b0;
            r_dist  <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_v1    <= i_valid && w_ready;
            r_drop  <= i_valid && !w_ready;
            r_valid <= r_v1;
            if (i_valid && w_ready) r_d1 <= w_d1;
            if (r_v1) r_dist <= w_sum;
        end
    end

    assign o_cfg_busy = (r_state == ST_BUILD);
    assign o_ready    = w_ready;
    assign o_valid    = r_valid;
    assign o_dist     = r_dist;
    assign o_drop     = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_branch_metric_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_metric_unit
// Brief    : Randomised self-checking bench for branch_metric_unit against a
//            direct encoder/distance reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_metric_unit;

    localparam int K  = 3;
    localparam int N  = 2;
    localparam int B  = 2;
    localparam int Q  = 3;
    localparam int S  = 4;
    localparam int NB = 4;
    localparam int CW = B*N;
    localparam int RXW = B*N*Q;
`ifdef BMU_SOFT_DECISION_EN
    localparam int MW   = $clog2(CW*((1<<Q)-1)+1);
    localparam bit SOFT = 1'b1;
`else
    localparam int MW   = $clog2(CW+1);
    localparam bit SOFT = 1'b0;
`endif
    localparam int DWID = S*NB*MW;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            i_cfg_we = 1'b0;
    logic [0:0]      i_cfg_idx = '0;
    logic [K-1:0]    i_cfg_poly = '0;
    logic            i_cfg_start = 1'b0;
    logic            o_cfg_busy, o_ready, o_valid, o_drop;
    logic            i_valid = 1'b0;
    logic [RXW-1:0]  i_rx = '0;
    logic [DWID-1:0] o_dist;

    always #5 clk = ~clk;

    branch_metric_unit #(.K(K), .N(N), .B(B), .Q(Q)) dut (
        .clk(clk), .rst(rst),
        .i_cfg_we(i_cfg_we), .i_cfg_idx(i_cfg_idx), .i_cfg_poly(i_cfg_poly),
        .i_cfg_start(i_cfg_start), .o_cfg_busy(o_cfg_busy), .o_ready(o_ready),
        .i_valid(i_valid), .i_rx(i_rx),
        .o_valid(o_valid), .o_dist(o_dist), .o_drop(o_drop)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int              due;
        logic [DWID-1:0] vec;
    } item_t;

    int              m_poly [N];
    int              m_tbl  [N];
    int              m_left;
    bit              m_ready;
    logic [DWID-1:0] m_last;
    item_t           m_q [$];
    int              cyc = 0;

    // Encode each (state, branch) directly and score the received slots.
    function automatic logic [DWID-1:0] model_dist(input logic [RXW-1:0] rx, input int pol [N]);
        logic [DWID-1:0] res;
        res = '0;
        for (int s = 0; s < S; s++) begin
            for (int b = 0; b < NB; b++) begin
                int st, metric;
                st = s;
                metric = 0;
                for (int t = 0; t < B; t++) begin
                    int u, r;
                    u = (b >> (B-1-t)) & 1;
                    r = (u << (K-1)) | st;
                    for (int j = 0; j < N; j++) begin
                        int e, sym;
                        e   = $countones(r & pol[j]) % 2;
                        sym = int'(rx >> ((t*N+j)*Q)) & ((1<<Q)-1);
                        if (SOFT) metric += (e == 1) ? ((1<<Q)-1-sym) : sym;
                        else      metric += ((sym >> (Q-1)) & 1) ^ e;
                    end
                    st = r >> 1;
                end
                res[(s*NB+b)*MW +: MW] = MW'(metric);
            end
        end
        return res;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < N; j++) begin
            m_poly[j] = 0;
            m_tbl[j]  = 0;
        end
        m_left  = 0;
        m_ready = 1'b0;
        m_last  = '0;
        m_q.delete();
    endtask

    task automatic step(input bit v, input logic [RXW-1:0] rx, input bit st,
                        input bit we, input int idx, input int poly);
        bit exp_drop;
        i_valid     = v;
        i_rx        = rx;
        i_cfg_start = st;
        i_cfg_we    = we;
        i_cfg_idx   = 1'(idx);
        i_cfg_poly  = K'(poly);
        exp_drop    = v && !m_ready;
        if (v && m_ready) m_q.push_back('{cyc+2, model_dist(rx, m_tbl)});
        if (we && m_left == 0) m_poly[idx] = poly;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_ready = 1'b1;
        end else if (st) begin
            m_left  = S;
            m_ready = 1'b0;
            m_tbl   = m_poly;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        i_valid = 1'b0; i_cfg_start = 1'b0; i_cfg_we = 1'b0;
        check("busy",  o_cfg_busy, m_left > 0);
        check("ready", o_ready, m_ready);
        check("drop",  o_drop, exp_drop);
        if (m_q.size() > 0 && m_q[0].due == cyc) begin
            check("valid", o_valid, 1);
            m_last = m_q[0].vec;
            void'(m_q.pop_front());
        end else begin
            check("valid", o_valid, 0);
        end
        check("dist", o_dist, m_last);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0, 0);
    endtask

    task automatic stream_one(input logic [RXW-1:0] rx);
        step(1, rx, 0, 0, 0, 0);
        step(0, '0, 0, 0, 0, 0);
    endtask

    task automatic write_polys(input int p0, input int p1);
        step(0, '0, 0, 1, 0, p0);
        step(0, '0, 0, 1, 1, p1);
    endtask

    initial begin
        int cnt;
        int guard;
        logic [RXW-1:0] rx;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_busy",  o_cfg_busy, 0);
        check("rst_ready", o_ready, 0);
        check("rst_valid", o_valid, 0);
        check("rst_drop",  o_drop, 0);
        check("rst_dist",  o_dist, 0);
        rst = 1'b1;
        @(negedge clk);

        // Symbols before any build are dropped.
        step(1, RXW'($urandom), 0, 0, 0, 0);
        idle(3);

        // Reset part-way through a build.
        write_polys(7, 5);
        step(0, '0, 1, 0, 0, 0);
        idle(1);
        rst = 1'b0;
        #1;
        check("midrst_ready", o_ready, 0);
        check("midrst_busy",  o_cfg_busy, 0);
        check("midrst_dist",  o_dist, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Fresh build; a poly write during BUILD must be ignored.
        write_polys(7, 5);
        step(0, '0, 1, 0, 0, 0);
        cnt = o_cfg_busy ? 1 : 0;
        step(0, '0, 0, 1, 0, 0);
        if (o_cfg_busy) cnt++;
        guard = 0;
        while (!o_ready && guard < 20) begin
            idle(1);
            if (o_cfg_busy) cnt++;
            guard++;
        end
        check("build_busy_cycles", cnt, S);

        stream_one('0);
        check("s0b0_zero", o_dist[0 +: MW], 0);
        check("s0b3_zero", o_dist[3*MW +: MW], SOFT ? 21 : 3);
        stream_one('1);
        check("s0b0_ones", o_dist[0 +: MW], SOFT ? 28 : 4);
        stream_one(12'h924);
        check("s0b0_100", o_dist[0 +: MW], SOFT ? 16 : 4);
        stream_one(12'h6DB);
        check("s0b0_011", o_dist[0 +: MW], SOFT ? 12 : 0);

        cnt = 0;
        for (int i = 0; i < 7; i++) begin
            step(i < 5, RXW'($urandom), 0, 0, 0, 0);
            if (o_valid) cnt++;
        end
        check("b2b_valid_count", cnt, 5);

        // Rebuild with zero polys while streaming.
        write_polys(0, 0);
        for (int i = 0; i < 3; i++) step(1, RXW'($urandom), 0, 0, 0, 0);
        step(1, '1, 1, 0, 0, 0);
        step(1, RXW'($urandom), 0, 0, 0, 0);
        check("old_tbl_in_flight", o_dist[0 +: MW], SOFT ? 28 : 4);
        for (int i = 0; i < S; i++) step(1, RXW'($urandom), 0, 0, 0, 0);
        stream_one('0);
        check("zero_poly_all", o_dist, 0);

        // Randomised traffic with occasional reprogramming.
        write_polys(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        step(0, '0, 1, 0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            rx = RXW'($urandom);
            step($urandom_range(0, 3) != 0, rx, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 9) == 0, int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 7)));
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
